// File: rtl/miriscv_mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between fetch and LSU.
// Define MIRISCV_ARB_RR_EN for round-robin arbitration; default is fixed data-over-instr priority.
module miriscv_mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic                clk_i,
  input  logic                arstn_i,

  input  logic                instr_req_i,
  input  logic [XLEN-1:0]     instr_addr_i,
  output logic                instr_rvalid_o,
  output logic [XLEN-1:0]     instr_rdata_o,

  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [XLEN/8-1:0]   data_be_i,
  input  logic [XLEN-1:0]     data_addr_i,
  input  logic [XLEN-1:0]     data_wdata_i,
  output logic                data_rvalid_o,
  output logic [XLEN-1:0]     data_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,

  output logic                arb_err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;   // 0 = instr, 1 = data
  logic   err_q, err_d;
  logic   grant_data;
  logic   any_req;

  assign any_req = instr_req_i | data_req_i;

`ifdef MIRISCV_ARB_RR_EN
  // prio_q names the port that wins the next tie; it flips to the other port on every grant.
  logic prio_q, prio_d;

  always_comb begin
    grant_data = data_req_i & (~instr_req_i | prio_q);
    prio_d     = prio_q;
    if ((state_q == IDLE) && any_req) begin
      prio_d = ~grant_data;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  always_comb begin
    grant_data = data_req_i;
  end
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    err_d          = (state_q == IDLE) & mem_rvalid_i;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;

    case (state_q)
      IDLE: begin
        // A response seen here is stray; it only feeds err_d and never blocks a new issue.
        if (any_req) begin
          mem_req_o = 1'b1;
          owner_d   = grant_data;
          state_d   = BUSY;
          if (grant_data) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
          end else begin
            mem_be_o    = '1;
            mem_addr_o  = instr_addr_i;
          end
        end
      end
      BUSY: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_q) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = mem_rdata_i;
          end else begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign arb_err_o = err_q;

endmodule

// File: doc/miriscv_mem_arbiter.md
# miriscv_mem_arbiter

Shares one memory port (req/we/be/addr/wdata, rvalid/rdata) between the miriscv fetch port and the data LSU port, so the core can run against a single-port unified memory. One transaction is outstanding at a time. A two-state FSM owns the port, routes the response back to the issuing requester and flags stray responses.

## Interface
- `XLEN`, 32: data/address width; byte-enable width is XLEN/8.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `arstn_i`  in  1  asynchronous active-low reset.
- `instr_req_i`  in  1  fetch request; held high until `instr_rvalid_o`.
- `instr_addr_i`  in  XLEN  fetch address; stable while `instr_req_i` is high.
- `instr_rvalid_o`  out  1  fetch response valid, one-cycle pulse.
- `instr_rdata_o`  out  XLEN  fetch data, valid with `instr_rvalid_o`.
- `data_req_i`  in  1  LSU request; held high until `data_rvalid_o`.
- `data_we_i`  in  1  1 = store, 0 = load.
- `data_be_i`  in  XLEN/8  store byte enables.
- `data_addr_i`  in  XLEN  LSU address.
- `data_wdata_i`  in  XLEN  store data.
- `data_rvalid_o`  out  1  LSU response valid, one-cycle pulse.
- `data_rdata_o`  out  XLEN  load data, valid with `data_rvalid_o`.
- `mem_req_o`  out  1  memory request, one-cycle pulse per transaction.
- `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o`  out  1/XLEN/8/XLEN/XLEN  request fields, valid with `mem_req_o`.
- `mem_rvalid_i`  in  1  memory response, arriving at least 1 cycle after `mem_req_o`.
- `mem_rdata_i`  in  XLEN  response data.
- `arb_err_o`  out  1  one-cycle pulse when `mem_rvalid_i` arrives with no transaction outstanding.

## Operation
- FSM states:
  - IDLE (reset state).
  - BUSY, with a registered `owner` bit: 0 = instr, 1 = data.
- IDLE behaviour:
  - No request: `mem_req_o` = 0 and the state holds.
  - At least one request: pick a winner (see Configuration).
  - Same cycle: drive `mem_req_o` = 1 with the winner's fields combinationally.
  - Register `owner` and go to BUSY.
- Instr winner field values:
  - `mem_we_o` = 0.
  - `mem_be_o` = all ones.
  - `mem_wdata_o` = 0.
  - `mem_addr_o` = `instr_addr_i`.
- BUSY behaviour:
  - `mem_req_o` = 0, and all `mem_*` request fields are driven to 0.
  - Inputs from both requesters are ignored.
  - On `mem_rvalid_i`: pulse the owner's `*_rvalid_o`, pass `mem_rdata_i` to the owner's `*_rdata_o`, return to IDLE.
- Rdata outputs are zero whenever their rvalid is low. This is a combinational gate, not a register.
- `mem_rvalid_i` in IDLE:
  - Response is discarded; no requester rvalid is raised.
  - `arb_err_o` = 1 for that cycle, registered so the pulse appears 1 cycle later.
  - If a request is also present that cycle, it is still issued normally.
- Stores complete like loads: the requester waits for `mem_rvalid_i`. rdata is don't-care and is passed through as received.
- Reset mid-transaction:
  - FSM returns to IDLE and the outstanding transaction is dropped.
  - A late `mem_rvalid_i` after reset raises `arb_err_o` and is discarded.

## Timing
- Reset values: `mem_req_o`/`mem_we_o` = 0, `mem_be_o`/`mem_addr_o`/`mem_wdata_o` = 0, both `*_rvalid_o` = 0, both `*_rdata_o` = 0, `arb_err_o` = 0, state IDLE, round-robin pointer = instr (owner 0).
- Issue latency: 0 cycles. A request seen in IDLE is on `mem_req_o` in the same cycle.
- Response latency: 0 cycles. `mem_rvalid_i` appears as the owner's rvalid in the same cycle.
- Back-to-back throughput: rvalid in cycle N returns the FSM to IDLE at N+1, where the next request may issue. The minimum transaction period is therefore 2 cycles when memory answers in 1 cycle.
- A requester may drop and re-raise its req in the cycle after its rvalid; this is treated as a new request.
- Requests are never issued in the same cycle as a response.

## Configuration
- Macro: `MIRISCV_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the port not granted last wins.
  - The pointer updates on every grant.
  - Neither port waits more than one transaction.
- Undefined: fixed priority, data port wins over instr.
  - Sustained LSU traffic may starve fetch. This is acceptable: the pipeline stalls fetch while the LSU is busy.

## Test plan
- Reset, then `instr_req_i` = 1 at 0x0000_0080; memory answers 2 cycles later with 0x0000_0013.
  - `mem_req_o` pulses once with addr 0x80 and be 0xF.
  - `instr_rvalid_o` pulses with 0x0000_0013.
  - `data_rvalid_o` stays 0.
- Store: `data_we_i` = 1, be 0x3, addr 0x1000, wdata 0xDEAD_BEEF.
  - Memory sees exactly these fields.
  - `data_rvalid_o` pulses on response.
  - A second `mem_req_o` is not issued while BUSY even though `data_req_i` stays high.
- Both ports request in the same IDLE cycle, repeated 3 times:
  - Without the macro: order is data, data, data.
  - With `MIRISCV_ARB_RR_EN`: order alternates instr, data, instr, starting from the reset pointer.
- `mem_rvalid_i` pulsed while IDLE with rdata 0x1234_5678:
  - `arb_err_o` pulses 1 cycle later.
  - Neither `*_rvalid_o` rises.
- `arstn_i` asserted while BUSY (data owner), released, then `mem_rvalid_i` pulses:
  - All outputs read their reset values during reset.
  - The post-reset response raises `arb_err_o` only.
- Memory with 1-cycle latency and continuous `instr_req_i`:
  - `mem_req_o` is high every second cycle.
  - Each rvalid returns the correct word for its address.
